// File: rtl/regfile_rat_ckpt_pkg.sv
// rtl/regfile_rat_ckpt_pkg.sv - shared constants and RAT entry type for the renaming register file
package regfile_rat_ckpt_pkg;
  localparam int ROB_WIDTH_BIT = 4;
  localparam int NUM_CKPT_DEF  = 4;
  localparam int NUM_REGS      = 32;
  localparam int REG_W         = 5;

  typedef struct packed {
    logic                     busy;
    logic [ROB_WIDTH_BIT-1:0] dep;
  } rat_entry_t;
endpackage

// File: rtl/rat_ckpt_buf.sv
// rtl/rat_ckpt_buf.sv - circular buffer of RAT snapshots with commit-clear broadcast and restore read-out
module rat_ckpt_buf
  import regfile_rat_ckpt_pkg::*;
#(
  parameter int NUM_COMMIT = 2,
  parameter int ROB_W      = ROB_WIDTH_BIT,
  parameter int NUM_CKPT   = NUM_CKPT_DEF,
  localparam int CK_W      = $clog2(NUM_CKPT)
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            flush,
  input  logic                            ck_alloc,
  input  logic                            ck_release,
  input  logic                            ck_restore,
  input  logic [CK_W-1:0]                 ck_restore_id,
  input  logic [NUM_COMMIT-1:0]           cm_eff,
  input  logic [NUM_COMMIT*REG_W-1:0]     cm_rd,
  input  logic [NUM_COMMIT*ROB_W-1:0]     cm_rob,
  input  logic [NUM_REGS-1:0]             live_busy,
  input  logic [NUM_REGS-1:0][ROB_W-1:0]  live_dep,
  output logic [NUM_REGS-1:0]             snap_busy,
  output logic [NUM_REGS-1:0][ROB_W-1:0]  snap_dep,
  output logic [CK_W-1:0]                 ck_id,
  output logic                            ck_full
);
  logic [NUM_REGS-1:0]            sb_busy [NUM_CKPT];
  logic [NUM_REGS-1:0][ROB_W-1:0] sb_dep  [NUM_CKPT];
  logic [CK_W-1:0] head_q, tail_q, head_nxt, tail_nxt;
  logic [CK_W:0]   count_q, count_nxt;
  logic            alloc_ok, rel_ok;

  assign snap_busy = sb_busy[ck_restore_id];
  assign snap_dep  = sb_dep[ck_restore_id];
  assign ck_id     = tail_q;
  assign rel_ok    = ck_release && (count_q != '0);
  assign alloc_ok  = ck_alloc && !ck_full;

  always_comb begin
    head_nxt  = head_q + CK_W'(rel_ok);
    tail_nxt  = tail_q;
    count_nxt = count_q;
    if (flush) begin
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
    end else if (ck_restore) begin
      tail_nxt = ck_restore_id;
      // Releasing the slot being restored empties the buffer; keep head aligned with tail.
      if (rel_ok && (head_q == ck_restore_id)) begin
        head_nxt  = ck_restore_id;
        count_nxt = '0;
      end else begin
        count_nxt = {1'b0, ck_restore_id - head_nxt};
      end
    end else begin
      tail_nxt  = tail_q + CK_W'(alloc_ok);
      count_nxt = count_q + (CK_W+1)'(alloc_ok) - (CK_W+1)'(rel_ok);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ck_full <= 1'b0;
      for (int s = 0; s < NUM_CKPT; s++) begin
        sb_busy[s] <= '0;
        sb_dep[s]  <= '0;
      end
    end else if (rdy_in) begin
      head_q  <= head_nxt;
      tail_q  <= tail_nxt;
      count_q <= count_nxt;
      ck_full <= (count_nxt == (CK_W+1)'(NUM_CKPT));
      for (int s = 0; s < NUM_CKPT; s++) begin
        for (int i = 0; i < NUM_COMMIT; i++) begin
          if (cm_eff[i] && (sb_dep[s][cm_rd[i*REG_W +: REG_W]] == cm_rob[i*ROB_W +: ROB_W]))
            sb_busy[s][cm_rd[i*REG_W +: REG_W]] <= 1'b0;
        end
      end
      if (alloc_ok && !flush && !ck_restore) begin
        sb_busy[tail_q] <= live_busy;
        sb_dep[tail_q]  <= live_dep;
      end
    end
  end
endmodule

// File: rtl/regfile_rat_ckpt.sv
// rtl/regfile_rat_ckpt.sv - register file with rename alias table and branch checkpoints
// Snapshot buffer is built only when REGFILE_CKPT_EN is defined.
module regfile_rat_ckpt
  import regfile_rat_ckpt_pkg::*;
#(
  parameter int NUM_READ   = 4,
  parameter int NUM_COMMIT = 2,
  parameter int ROB_W      = ROB_WIDTH_BIT,
  parameter int NUM_CKPT   = NUM_CKPT_DEF,
  localparam int CK_W      = $clog2(NUM_CKPT)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush,
  input  logic [REG_W-1:0]            ren_rd,
  input  logic [ROB_W-1:0]            ren_rob,
  input  logic [NUM_COMMIT*REG_W-1:0] cm_rd,
  input  logic [NUM_COMMIT*32-1:0]    cm_val,
  input  logic [NUM_COMMIT*ROB_W-1:0] cm_rob,
  input  logic [NUM_READ*REG_W-1:0]   rd_id,
  output logic [NUM_READ*32-1:0]      rd_val,
  output logic [NUM_READ-1:0]         rd_has_dep,
  output logic [NUM_READ*ROB_W-1:0]   rd_dep,
  output logic [NUM_READ*ROB_W-1:0]   rob_q_id,
  input  logic [NUM_READ-1:0]         rob_q_ready,
  input  logic [NUM_READ*32-1:0]      rob_q_val,
  input  logic                        ck_alloc,
  output logic [CK_W-1:0]             ck_id,
  output logic                        ck_full,
  input  logic                        ck_release,
  input  logic                        ck_restore,
  input  logic [CK_W-1:0]             ck_restore_id
);
  logic [NUM_REGS-1:0][31:0]      val_q;
  logic [NUM_REGS-1:0]            busy_q, busy_nxt, snap_busy;
  logic [NUM_REGS-1:0][ROB_W-1:0] dep_q, dep_nxt, snap_dep;
  logic [NUM_COMMIT-1:0]          cm_eff;
  logic                           restore_act;

  // A lane only clears busy when no younger lane commits the same register.
  always_comb begin
    cm_eff = '0;
    for (int i = 0; i < NUM_COMMIT; i++) begin
      cm_eff[i] = (cm_rd[i*REG_W +: REG_W] != '0);
      for (int j = i + 1; j < NUM_COMMIT; j++)
        if (cm_rd[j*REG_W +: REG_W] == cm_rd[i*REG_W +: REG_W]) cm_eff[i] = 1'b0;
    end
  end

  always_comb begin
    busy_nxt = restore_act ? snap_busy : busy_q;
    dep_nxt  = restore_act ? snap_dep : dep_q;
    for (int i = 0; i < NUM_COMMIT; i++) begin
      if (cm_eff[i] && (dep_nxt[cm_rd[i*REG_W +: REG_W]] == cm_rob[i*ROB_W +: ROB_W]))
        busy_nxt[cm_rd[i*REG_W +: REG_W]] = 1'b0;
    end
    if (!restore_act && (ren_rd != '0)) begin
      dep_nxt[ren_rd]  = ren_rob;
      busy_nxt[ren_rd] = 1'b1;
    end
  end

  always_comb begin
    logic [REG_W-1:0] id;
    logic [ROB_W-1:0] qid;
    id         = '0;
    qid        = '0;
    rd_val     = '0;
    rd_has_dep = '0;
    rd_dep     = '0;
    rob_q_id   = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      id  = rd_id[p*REG_W +: REG_W];
      qid = (ren_rd == id) ? ren_rob : dep_q[id];
      rob_q_id[p*ROB_W +: ROB_W] = qid;
      rd_dep[p*ROB_W +: ROB_W]   = qid;
      rd_has_dep[p] = ((ren_rd != '0) && (ren_rd == id)) || (busy_q[id] && !rob_q_ready[p]);
      rd_val[p*32 +: 32] = busy_q[id] ? rob_q_val[p*32 +: 32] : val_q[id];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      val_q  <= '0;
      busy_q <= '0;
      dep_q  <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < NUM_COMMIT; i++) begin
        if (cm_rd[i*REG_W +: REG_W] != '0)
          val_q[cm_rd[i*REG_W +: REG_W]] <= cm_val[i*32 +: 32];
      end
      if (flush) begin
        busy_q <= '0;
        dep_q  <= '0;
      end else begin
        busy_q <= busy_nxt;
        dep_q  <= dep_nxt;
      end
    end
  end

`ifdef REGFILE_CKPT_EN
  assign restore_act = ck_restore && !flush;

  rat_ckpt_buf #(
    .NUM_COMMIT (NUM_COMMIT),
    .ROB_W      (ROB_W),
    .NUM_CKPT   (NUM_CKPT)
  ) u_buf (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush         (flush),
    .ck_alloc      (ck_alloc),
    .ck_release    (ck_release),
    .ck_restore    (ck_restore),
    .ck_restore_id (ck_restore_id),
    .cm_eff        (cm_eff),
    .cm_rd         (cm_rd),
    .cm_rob        (cm_rob),
    .live_busy     (busy_nxt),
    .live_dep      (dep_nxt),
    .snap_busy     (snap_busy),
    .snap_dep      (snap_dep),
    .ck_id         (ck_id),
    .ck_full       (ck_full)
  );
`else
  logic unused_ck;
  assign unused_ck   = ^{ck_alloc, ck_release, ck_restore, ck_restore_id};
  assign restore_act = 1'b0;
  assign snap_busy   = '0;
  assign snap_dep    = '0;
  assign ck_id       = '0;
  assign ck_full     = 1'b1;
`endif
endmodule

// File: tb/tb_regfile_rat_ckpt.sv
// tb/tb_regfile_rat_ckpt.sv - vector-table and scoreboard bench for regfile_rat_ckpt
module tb_regfile_rat_ckpt;
`ifdef REGFILE_CKPT_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int NF = (CK != 0) ? 0 : 1;
  localparam int FL = 8, AL = 4, RL = 2, RS = 1;

  typedef struct {
    string       name;
    logic [4:0]  ren_rd;
    logic [3:0]  ren_rob;
    logic [4:0]  a_rd;
    logic [3:0]  a_rob;
    logic [31:0] a_val;
    logic [4:0]  b_rd;
    logic [3:0]  b_rob;
    logic [31:0] b_val;
    logic [3:0]  ops;
    logic [1:0]  rs_id;
    logic        rdy;
    logic [4:0]  rid;
    logic        qrdy;
    logic [31:0] qval;
    logic        e_has;
    logic [3:0]  e_dep;
    logic [31:0] e_val;
    logic        e_full;
    logic [1:0]  e_ckid;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic [4:0]  ren_rd;
  logic [3:0]  ren_rob;
  logic [9:0]  cm_rd;
  logic [63:0] cm_val;
  logic [7:0]  cm_rob;
  logic [19:0] rd_id;
  logic [127:0] rd_val;
  logic [3:0]  rd_has_dep;
  logic [15:0] rd_dep, rob_q_id;
  logic [3:0]  rob_q_ready;
  logic [127:0] rob_q_val;
  logic        ck_alloc, ck_full, ck_release, ck_restore;
  logic [1:0]  ck_id, ck_restore_id;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk_in = ~clk_in;

  regfile_rat_ckpt dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .ren_rd(ren_rd), .ren_rob(ren_rob),
    .cm_rd(cm_rd), .cm_val(cm_val), .cm_rob(cm_rob),
    .rd_id(rd_id), .rd_val(rd_val), .rd_has_dep(rd_has_dep), .rd_dep(rd_dep),
    .rob_q_id(rob_q_id), .rob_q_ready(rob_q_ready), .rob_q_val(rob_q_val),
    .ck_alloc(ck_alloc), .ck_id(ck_id), .ck_full(ck_full),
    .ck_release(ck_release), .ck_restore(ck_restore), .ck_restore_id(ck_restore_id)
  );

  function automatic vec_t mk(input string nm, input int rr, input int rb,
                              input int ard, input int arob, input int aval,
                              input int brd, input int brob, input int bval,
                              input int ops, input int rsid, input int rdy,
                              input int rid, input int qr, input int qv,
                              input int eh, input int ed, input int ev, input int ef, input int ec);
    vec_t v;
    v.name = nm;    v.ren_rd = 5'(rr);  v.ren_rob = 4'(rb);
    v.a_rd = 5'(ard); v.a_rob = 4'(arob); v.a_val = 32'(aval);
    v.b_rd = 5'(brd); v.b_rob = 4'(brob); v.b_val = 32'(bval);
    v.ops = 4'(ops); v.rs_id = 2'(rsid); v.rdy = 1'(rdy);
    v.rid = 5'(rid); v.qrdy = 1'(qr); v.qval = 32'(qv);
    v.e_has = 1'(eh); v.e_dep = 4'(ed); v.e_val = 32'(ev); v.e_full = 1'(ef); v.e_ckid = 2'(ec);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    ren_rd = v.ren_rd;  ren_rob = v.ren_rob;
    cm_rd  = {v.b_rd, v.a_rd};
    cm_rob = {v.b_rob, v.a_rob};
    cm_val = {v.b_val, v.a_val};
    flush = v.ops[3]; ck_alloc = v.ops[2]; ck_release = v.ops[1]; ck_restore = v.ops[0];
    ck_restore_id = v.rs_id;
    rdy_in = v.rdy;
    rd_id = {5'd0, v.rid, v.rid, v.rid};
    rob_q_ready = {1'b0, v.qrdy, v.qrdy, v.qrdy};
    rob_q_val = {32'hDEAD_BEEF, v.qval, v.qval, v.qval};
    exp_q.push_back(v);
    @(negedge clk_in);
    e = exp_q.pop_front();
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("%s has_dep[%0d]", e.name, p), 32'(rd_has_dep[p]), 32'(e.e_has));
      chk($sformatf("%s rd_dep[%0d]", e.name, p), 32'(rd_dep[p*4 +: 4]), 32'(e.e_dep));
      chk($sformatf("%s rob_q_id[%0d]", e.name, p), 32'(rob_q_id[p*4 +: 4]), 32'(e.e_dep));
      chk($sformatf("%s rd_val[%0d]", e.name, p), rd_val[p*32 +: 32], e.e_val);
    end
    chk($sformatf("%s x0_val", e.name), rd_val[96 +: 32], 32'h0);
    chk($sformatf("%s x0_has_dep", e.name), 32'(rd_has_dep[3]), 32'h0);
    chk($sformatf("%s ck_full", e.name), 32'(ck_full), 32'(e.e_full));
    chk($sformatf("%s ck_id", e.name), 32'(ck_id), 32'(e.e_ckid));
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    //             name                rr rb  a_rd,rob,val   b_rd,rob,val  ops rs rdy rid qr qv     eh  ed  ev     full ckid
    tbl.push_back(mk("reset_state",     0, 0,  0,0,0,        0,0,0,        0,  0, 1,  5, 0, 0,     0,  0,  0,     NF, 0));
    tbl.push_back(mk("ren_bypass",      5, 3,  0,0,0,        0,0,0,        0,  0, 1,  5, 0, 0,     1,  3,  0,     NF, 0));
    tbl.push_back(mk("fwd_ready",       0, 0,  0,0,0,        0,0,0,        0,  0, 1,  5, 1, 'hAB,  0,  3,  'hAB,  NF, 0));
    tbl.push_back(mk("fwd_wait",        0, 0,  0,0,0,        0,0,0,        0,  0, 1,  5, 0, 'hCD,  1,  3,  'hCD,  NF, 0));
    tbl.push_back(mk("commit_vs_ren",   5, 6,  5,3,'h11,     0,0,0,        0,  0, 1,  5, 0, 0,     1,  6,  0,     NF, 0));
    tbl.push_back(mk("busy_kept",       0, 0,  0,0,0,        0,0,0,        0,  0, 1,  5, 0, 'h55,  1,  6,  'h55,  NF, 0));
    tbl.push_back(mk("commit_clear",    0, 0,  0,0,0,        5,6,'h22,     0,  0, 1,  5, 0, 'h77,  1,  6,  'h77,  NF, 0));
    tbl.push_back(mk("val_written",     0, 0,  0,0,0,        0,0,0,        0,  0, 1,  5, 0, 0,     0,  6,  'h22,  NF, 0));
    tbl.push_back(mk("dual_commit",     0, 0,  7,1,1,        7,2,2,        0,  0, 1,  7, 0, 0,     0,  0,  0,     NF, 0));
    tbl.push_back(mk("lane1_wins",      0, 0,  0,0,0,        0,0,0,        0,  0, 1,  7, 0, 0,     0,  0,  2,     NF, 0));
    tbl.push_back(mk("ren_x8",          8, 4,  0,0,0,        0,0,0,        0,  0, 1,  8, 0, 0,     1,  4,  0,     NF, 0));
    tbl.push_back(mk("younger_same_rd", 0, 0,  8,4,'h33,     8,9,'h44,     0,  0, 1,  8, 0, 0,     1,  4,  0,     NF, 0));
    tbl.push_back(mk("older_blocked",   0, 0,  0,0,0,        0,0,0,        0,  0, 1,  8, 0, 'h99,  1,  4,  'h99,  NF, 0));
    tbl.push_back(mk("younger_clears",  0, 0,  8,1,5,        8,4,6,        0,  0, 1,  8, 0, 0,     1,  4,  0,     NF, 0));
    tbl.push_back(mk("x8_free",         0, 0,  0,0,0,        0,0,0,        0,  0, 1,  8, 0, 0,     0,  4,  6,     NF, 0));
    tbl.push_back(mk("x0_ren_ignored",  0, 5,  0,0,'hFF,     0,0,0,        0,  0, 1,  0, 0, 0,     0,  5,  0,     NF, 0));
    tbl.push_back(mk("x0_reads_zero",   0, 0,  0,0,0,        0,0,0,        0,  0, 1,  0, 0, 0,     0,  0,  0,     NF, 0));
    tbl.push_back(mk("ck_alloc",        0, 0,  0,0,0,        0,0,0,        AL, 0, 1,  9, 0, 0,     0,  0,  0,     NF, 0));
    tbl.push_back(mk("ren_x9",          9, 8,  0,0,0,        0,0,0,        0,  0, 1,  9, 0, 0,     1,  8,  0,     NF, CK));
    tbl.push_back(mk("restore_cycle",   0, 0,  0,0,0,        0,0,0,        RS, 0, 1,  9, 0, 'h12,  1,  8,  'h12,  NF, CK));
    for (int k = 0; k < 6; k++) begin
      int op, ef, ec;
      op = (k == 0) ? 0 : (k <= 5 && k >= 1 && k != 5) ? AL : 0;
      ef = NF; ec = 0;
      if (k >= 1 && k <= 4) ec = (CK != 0) ? k - 1 : 0;
      if (k == 5) begin op = AL; ef = 1; end
      tbl.push_back(mk($sformatf("restored_%0d", k), 0, 0, 0,0,0, 0,0,0, op, 0, 1, 9, 0, 'h34,
                       (CK != 0) ? 0 : 1, (CK != 0) ? 0 : 8, (CK != 0) ? 0 : 'h34, ef, ec));
    end
    tbl.push_back(mk("release_full",    0, 0,  0,0,0,        0,0,0,        RL, 0, 1,  9, 0, 'h34,  (CK != 0) ? 0 : 1, (CK != 0) ? 0 : 8, (CK != 0) ? 0 : 'h34, 1, 0));
    tbl.push_back(mk("after_release",   0, 0,  0,0,0,        0,0,0,        0,  0, 1,  9, 0, 'h34,  (CK != 0) ? 0 : 1, (CK != 0) ? 0 : 8, (CK != 0) ? 0 : 'h34, NF, 0));
    tbl.push_back(mk("flush",           4, 2,  10,0,'hA0,    0,0,0,        FL, 0, 1,  4, 0, 0,     1,  2,  0,     NF, 0));
    tbl.push_back(mk("flush_drops_ren", 0, 0,  0,0,0,        0,0,0,        0,  0, 1,  4, 0, 0,     0,  0,  0,     NF, 0));
    tbl.push_back(mk("flush_keeps_val", 0, 0,  0,0,0,        0,0,0,        0,  0, 1, 10, 0, 0,     0,  0,  'hA0,  NF, 0));
    tbl.push_back(mk("alloc_x4",        4, 2,  0,0,0,        0,0,0,        AL, 0, 1,  4, 0, 0,     1,  2,  0,     NF, 0));
    tbl.push_back(mk("cm_rob2_reren",   4, 5,  4,2,'h44,     0,0,0,        0,  0, 1,  4, 0, 0,     1,  5,  0,     NF, CK));
    tbl.push_back(mk("restore_x4",      0, 0,  0,0,0,        0,0,0,        RS, 0, 1,  4, 0, 'h66,  1,  5,  'h66,  NF, CK));
    tbl.push_back(mk("x4_free",         0, 0,  0,0,0,        0,0,0,        0,  0, 1,  4, 0, 'h77,  (CK != 0) ? 0 : 1, (CK != 0) ? 2 : 5, (CK != 0) ? 'h44 : 'h77, NF, 0));

    rst_in = 1'b1;
    rdy_in = 1'b1; flush = 1'b0; ren_rd = '0; ren_rob = '0;
    cm_rd = '0; cm_val = '0; cm_rob = '0; rd_id = '0;
    rob_q_ready = '0; rob_q_val = '0;
    ck_alloc = 1'b0; ck_release = 1'b0; ck_restore = 1'b0; ck_restore_id = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    foreach (tbl[i]) step(tbl[i]);

    // rdy_in low freezes everything, then flush outranks a same-cycle restore
    step(mk("ren_x11",       11, 7, 0,0,0,     0,0,0, 0,       0, 1, 11, 0, 0,  1, 7, 0, NF, 0));
    step(mk("alloc_x11",      0, 0, 0,0,0,     0,0,0, AL,      0, 1, 11, 0, 1,  1, 7, 1, NF, 0));
    step(mk("rdy_low",       12, 3, 11,7,'h5A, 0,0,0, FL + AL, 0, 0, 12, 0, 0,  1, 3, 0, NF, CK));
    step(mk("frozen_busy",    0, 0, 0,0,0,     0,0,0, 0,       0, 1, 11, 0, 9,  1, 7, 9, NF, CK));
    step(mk("frozen_ren",     0, 0, 0,0,0,     0,0,0, 0,       0, 1, 12, 0, 0,  0, 0, 0, NF, CK));
    step(mk("flush_restore",  0, 0, 0,0,0,     0,0,0, FL + RS, 0, 1, 11, 0, 2,  1, 7, 2, NF, CK));
    step(mk("flush_wins",     0, 0, 0,0,0,     0,0,0, 0,       0, 1, 11, 0, 3,  0, 0, 0, NF, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
